// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 16-requester round-robin arbiter.
package arb_pkg;

  localparam int N_REQ              = 16;
  localparam int SEL_W              = 4;
  localparam int TIMEOUT_CYCLES_DEF = 64;
  localparam int TO_CNT_W           = $clog2(TIMEOUT_CYCLES_DEF);

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: rotate requests so ptr lands at bit 0,
// take the lowest set bit, then rotate the index back by adding ptr.
module rr_priority_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any_req
);

  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] idx;

  always_comb begin
    rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[SEL_W'(i) + ptr];
    end
  end

  // Descending scan so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) idx = SEL_W'(i);
    end
  end

  assign winner  = idx + ptr;
  assign any_req = |req;

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter steering the SELECT of a shared 16:1 mux; grant held until ACK.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
//
// state       | meaning
// ARB_IDLE    | no grant outstanding; any request is arbitrated on the next edge
// ARB_GRANTED | grant locked to one requester until ACK (or watchdog abort)
module rr_arbiter_16
  import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)
`endif
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_REQ-1:0] REQ,
  input  logic             ACK,
  output logic [N_REQ-1:0] GRANT,
  output logic [SEL_W-1:0] SELECT,
  output logic             BUSY,
  output logic             TIMEOUT
);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_d;
  logic [SEL_W-1:0] sel_d;
  logic             busy_d;
  logic             timeout_d;
  logic [SEL_W-1:0] winner;
  logic             any_req;

  rr_priority_pick u_pick (
    .req     (REQ),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = GRANT;
    sel_d     = SELECT;
    busy_d    = BUSY;
    timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          state_d = ARB_GRANTED;
          grant_d = N_REQ'(1) << winner;
          sel_d   = winner;
          busy_d  = 1'b1;
          ptr_d   = winner + SEL_W'(1);
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ARB_GRANTED: begin
        // ACK takes precedence over a watchdog expiry on the same edge.
        if (ACK) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ARB_IDLE;
          grant_d   = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      GRANT   <= '0;
      SELECT  <= '0;
      BUSY    <= 1'b0;
      TIMEOUT <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      GRANT   <= grant_d;
      SELECT  <= sel_d;
      BUSY    <= busy_d;
      TIMEOUT <= timeout_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Self-checking bench for rr_arbiter_16: directed vector table plus a randomised
// phase checked against a scan-based reference model, both through a scoreboard queue.
module tb_rr_arbiter_16;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] REQ;
  logic        ACK;
  logic [15:0] GRANT;
  logic [3:0]  SELECT;
  logic        BUSY;
  logic        TIMEOUT;

  always #5 CLK = ~CLK;

  rr_arbiter_16 dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .REQ     (REQ),
    .ACK     (ACK),
    .GRANT   (GRANT),
    .SELECT  (SELECT),
    .BUSY    (BUSY),
    .TIMEOUT (TIMEOUT)
  );

  typedef struct {
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        busy;
    logic        timeout;
  } exp_t;

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic        ack;
    exp_t        exp;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req_v);
    end
  endtask

  task automatic add(input logic r, input logic [15:0] q, input logic a,
                     input logic [15:0] g, input logic [3:0] s, input logic b);
    vec_t v;
    v.rst = r; v.req = q; v.ack = a;
    v.exp.grant = g; v.exp.sel = s; v.exp.busy = b; v.exp.timeout = 1'b0;
    tbl.push_back(v);
  endtask

  // Drive one cycle of stimulus, queue its expectation, check after the edge.
  task automatic drive(input string tag, input logic r, input logic [15:0] q,
                       input logic a, input exp_t e);
    exp_t got;
    @(negedge CLK);
    RESET = r; REQ = q; ACK = a;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    got = sb.pop_front();
    cmp({tag, " grant"},   32'(GRANT),   32'(got.grant));
    cmp({tag, " select"},  32'(SELECT),  32'(got.sel));
    cmp({tag, " busy"},    32'(BUSY),    32'(got.busy));
    cmp({tag, " timeout"}, 32'(TIMEOUT), 32'(got.timeout));
  endtask

  // Reference model state for the random phase.
  logic        m_st;
  logic [3:0]  m_ptr;
  exp_t        m_out;

  task automatic model_step(input logic r, input logic [15:0] q, input logic a);
    int w;
    m_out.timeout = 1'b0;
    if (r) begin
      m_st = 1'b0; m_ptr = '0;
      m_out.grant = '0; m_out.sel = '0; m_out.busy = 1'b0;
    end else if (!m_st) begin
      if (q != 0) begin
        w = -1;
        for (int k = 0; k < 16; k++) begin
          if (w < 0 && q[(int'(m_ptr) + k) % 16]) w = (int'(m_ptr) + k) % 16;
        end
        m_out.grant = 16'h0;
        m_out.grant[w] = 1'b1;
        m_out.sel  = 4'(w);
        m_out.busy = 1'b1;
        m_ptr = 4'((w + 1) % 16);
        m_st  = 1'b1;
      end
    end else if (a) begin
      m_out.grant = '0; m_out.busy = 1'b0; m_st = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] one;
    logic        r, a;
    logic [15:0] q;
    exp_t        z;
    z = '{16'h0, 4'h0, 1'b0, 1'b0};
    one = 16'h0001;
    RESET = 1'b1; REQ = '0; ACK = 1'b0;

    drive("reset0", 1'b1, 16'h0000, 1'b0, z);
    drive("reset1", 1'b1, 16'hFFFF, 1'b1, z);

    // single requester, ACK, bubble, regrant
    add(0, 16'h0001, 0, 16'h0001, 4'd0, 1);
    add(0, 16'h0001, 1, 16'h0000, 4'd0, 0);
    add(0, 16'h0001, 0, 16'h0001, 4'd0, 1);
    add(0, 16'h0000, 1, 16'h0000, 4'd0, 0);
    add(0, 16'h0000, 0, 16'h0000, 4'd0, 0);
    add(1, 16'hFFFF, 0, 16'h0000, 4'd0, 0);
    // all requesting: 0..15 then wrap to 0
    for (int k = 0; k <= 16; k++) begin
      add(0, 16'hFFFF, 0, one << (k % 16), 4'(k % 16), 1);
      add(0, 16'hFFFF, 1, 16'h0000,        4'(k % 16), 0);
    end
    // PTR=14 wraps past 14,15 to pick 0, then PTR=1 picks 3
    add(0, 16'h2000, 0, 16'h2000, 4'd13, 1);
    add(0, 16'h2000, 1, 16'h0000, 4'd13, 0);
    add(0, 16'h0009, 0, 16'h0001, 4'd0,  1);
    add(0, 16'h0009, 1, 16'h0000, 4'd0,  0);
    add(0, 16'h0009, 0, 16'h0008, 4'd3,  1);
    add(0, 16'h0000, 1, 16'h0000, 4'd3,  0);
    add(0, 16'h0000, 1, 16'h0000, 4'd3,  0);
    // grant lock while requester 5 drops and 9 rises; ACK with pending request
    add(0, 16'h0020, 0, 16'h0020, 4'd5,  1);
    add(0, 16'h0200, 0, 16'h0020, 4'd5,  1);
    add(0, 16'h0200, 0, 16'h0020, 4'd5,  1);
    add(0, 16'h0200, 1, 16'h0000, 4'd5,  0);
    add(0, 16'h0200, 0, 16'h0200, 4'd9,  1);
    add(0, 16'h0000, 1, 16'h0000, 4'd9,  0);
    // reset mid-grant clears PTR: with PTR=0, 16'h1080 picks 7, then 12
    add(0, 16'h0080, 0, 16'h0080, 4'd7,  1);
    add(1, 16'h0080, 1, 16'h0000, 4'd0,  0);
    add(0, 16'h1080, 0, 16'h0080, 4'd7,  1);
    add(0, 16'h1080, 1, 16'h0000, 4'd7,  0);
    add(0, 16'h1080, 0, 16'h1000, 4'd12, 1);
    add(0, 16'h0000, 1, 16'h0000, 4'd12, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive($sformatf("vec%0d", i), tbl[i].rst, tbl[i].req, tbl[i].ack, tbl[i].exp);
    end

    model_step(1'b1, 16'h0, 1'b0);
    drive("rnd_reset", 1'b1, 16'h0, 1'b0, m_out);
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 59) == 0);
      a = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       q = 16'h0;
        1:       q = one << $urandom_range(0, 15);
        2:       q = 16'($urandom) & 16'($urandom);
        default: q = 16'($urandom);
      endcase
      model_step(r, q, a);
      drive($sformatf("rnd%0d", i), r, q, a, m_out);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
